// File: rtl/roic_pixel_capture.sv
// Receive end of the ROIC row/column scan: decodes one-hot enables, checks
// integrity and raster order, and emits a marker-tagged pixel stream.
module roic_pixel_capture #(
    parameter int COLS   = 640,
    parameter int ROWS   = 512,
    parameter int COL_AW = 10,
    parameter int ROW_AW = 9,
    parameter int PIX_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   col_enable,
    input  logic [ROWS-1:0]   row_enable,
    input  logic [PIX_W-1:0]  pix_in,
    output logic              out_valid,
    output logic [PIX_W-1:0]  out_data,
    output logic [ROW_AW-1:0] out_row,
    output logic [COL_AW-1:0] out_col,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              err_onehot,
    output logic              err_order,
    output logic              locked,
    output logic [15:0]       frame_count
);

    typedef enum logic [1:0] {ENC_NONE, ENC_ONE, ENC_MANY} enc_t;
    typedef enum logic {HUNT, LOCKED} state_t;

    enc_t              col_cls, row_cls, s1_col_cls, s1_row_cls;
    logic [COL_AW-1:0] col_idx, s1_col, exp_col, last_col;
    logic [ROW_AW-1:0] row_idx, s1_row, exp_row, last_row;
    logic [PIX_W-1:0]  s1_pix;
    logic              have_last;
    state_t            state;

    // OR-ing every set index is exact only for a single set bit; the
    // classification tells stage 2 whether the index can be trusted.
    always_comb begin
        col_cls = ENC_NONE;
        col_idx = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (col_enable[i]) begin
                if (col_cls == ENC_NONE) col_cls = ENC_ONE;
                else                     col_cls = ENC_MANY;
                col_idx = col_idx | COL_AW'(i);
            end
        end
    end

    always_comb begin
        row_cls = ENC_NONE;
        row_idx = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (row_enable[i]) begin
                if (row_cls == ENC_NONE) row_cls = ENC_ONE;
                else                     row_cls = ENC_MANY;
                row_idx = row_idx | ROW_AW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_col_cls <= ENC_NONE;
            s1_row_cls <= ENC_NONE;
            s1_col     <= '0;
            s1_row     <= '0;
            s1_pix     <= '0;
        end else begin
            s1_col_cls <= col_cls;
            s1_row_cls <= row_cls;
            s1_col     <= col_idx;
            s1_row     <= row_idx;
            s1_pix     <= pix_in;
        end
    end

    logic any_none, any_many, is_dup, live, at_origin, at_exp;
    logic at_last_col, at_last_row, accept, order_err;

    always_comb begin
        any_none    = (s1_col_cls == ENC_NONE) || (s1_row_cls == ENC_NONE);
        any_many    = !any_none && ((s1_col_cls == ENC_MANY) || (s1_row_cls == ENC_MANY));
        is_dup      = have_last && (s1_row == last_row) && (s1_col == last_col);
        live        = !any_none && !any_many && !is_dup;
        at_origin   = (s1_row == '0) && (s1_col == '0);
        at_exp      = (s1_row == exp_row) && (s1_col == exp_col);
        at_last_col = (s1_col == COL_AW'(COLS - 1));
        at_last_row = (s1_row == ROW_AW'(ROWS - 1));
        accept      = live && ((state == HUNT) ? at_origin : (at_exp || at_origin));
        order_err   = live && (state == LOCKED) && !at_exp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            exp_row     <= '0;
            exp_col     <= '0;
            have_last   <= 1'b0;
            last_row    <= '0;
            last_col    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_row     <= '0;
            out_col     <= '0;
            out_sof     <= 1'b0;
            out_eol     <= 1'b0;
            out_eof     <= 1'b0;
            err_onehot  <= 1'b0;
            err_order   <= 1'b0;
            frame_count <= '0;
        end else begin
            out_valid  <= accept;
            out_sof    <= accept && at_origin;
            out_eol    <= accept && at_last_col;
            out_eof    <= accept && at_last_col && at_last_row;
            err_onehot <= any_many;
            err_order  <= order_err;
            if (accept) begin
                state     <= LOCKED;
                out_data  <= s1_pix;
                out_row   <= s1_row;
                out_col   <= s1_col;
                have_last <= 1'b1;
                last_row  <= s1_row;
                last_col  <= s1_col;
                if (at_last_col) begin
                    exp_col <= '0;
                    exp_row <= at_last_row ? '0 : s1_row + 1'b1;
                end else begin
                    exp_col <= s1_col + 1'b1;
                    exp_row <= s1_row;
                end
                if (at_last_col && at_last_row) frame_count <= frame_count + 16'd1;
            end else if (any_many) begin
                state   <= HUNT;
                exp_row <= '0;
                exp_col <= '0;
            end else if (order_err) begin
                state <= HUNT;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_roic_pixel_capture.sv
// Randomized bench for roic_pixel_capture on a reduced 40x24 raster, checked
// cycle by cycle against a linear-position reference model.
module tb_roic_pixel_capture;

    localparam int COLS = 40;
    localparam int ROWS = 24;
    localparam int CAW  = 6;
    localparam int RAW  = 5;
    localparam int PW   = 14;
    localparam int NPIX = COLS * ROWS;

    typedef struct packed {
        logic           valid;
        logic [PW-1:0]  data;
        logic [RAW-1:0] row;
        logic [CAW-1:0] col;
        logic           sof, eol, eof, eoh, eord, lock;
        logic [15:0]    fcnt;
    } snap_t;

    typedef struct packed {
        logic [COLS-1:0] cv;
        logic [ROWS-1:0] rv;
        logic [PW-1:0]   pix;
    } stim_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [COLS-1:0] col_enable = '0;
    logic [ROWS-1:0] row_enable = '0;
    logic [PW-1:0]   pix_in = '0;
    logic            out_valid, out_sof, out_eol, out_eof;
    logic [PW-1:0]   out_data;
    logic [RAW-1:0]  out_row;
    logic [CAW-1:0]  out_col;
    logic            err_onehot, err_order, locked;
    logic [15:0]     frame_count;

    roic_pixel_capture #(.COLS(COLS), .ROWS(ROWS), .COL_AW(CAW), .ROW_AW(RAW), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst), .col_enable(col_enable), .row_enable(row_enable),
        .pix_in(pix_in), .out_valid(out_valid), .out_data(out_data), .out_row(out_row),
        .out_col(out_col), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .err_onehot(err_onehot), .err_order(err_order), .locked(locked),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: position is row*COLS+col.
    bit          m_locked, m_have_last;
    int          m_exp, m_last, m_row, m_col;
    logic [PW-1:0] m_data;
    logic [15:0] m_fcnt;
    snap_t       exp_q[$];
    stim_t       sq[$];
    snap_t       got[$];
    snap_t       want[$];

    function automatic int idx_c(input logic [COLS-1:0] v);
        for (int i = 0; i < COLS; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int idx_r(input logic [ROWS-1:0] v);
        for (int i = 0; i < ROWS; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_have_last = 0; m_exp = 0; m_last = 0;
        m_row = 0; m_col = 0; m_data = '0; m_fcnt = '0;
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    task automatic model_step(input stim_t st, output snap_t s);
        int nc, nr, pos;
        bit take;
        s = '0;
        take = 0;
        nc = $countones(st.cv);
        nr = $countones(st.rv);
        if (nc == 0 || nr == 0) begin
        end else if (nc > 1 || nr > 1) begin
            s.eoh = 1'b1; m_locked = 0; m_exp = 0;
        end else begin
            pos = idx_r(st.rv) * COLS + idx_c(st.cv);
            if (m_have_last && pos == m_last) begin
            end else if (!m_locked) take = (pos == 0);
            else if (pos == m_exp) take = 1;
            else if (pos == 0) begin s.eord = 1'b1; take = 1; end
            else begin s.eord = 1'b1; m_locked = 0; end
            if (take) begin
                m_locked = 1; m_have_last = 1; m_last = pos;
                m_exp = (pos + 1) % NPIX;
                m_data = st.pix; m_row = pos / COLS; m_col = pos % COLS;
                s.valid = 1'b1;
                s.sof = (pos == 0);
                s.eol = (m_col == COLS - 1);
                s.eof = (pos == NPIX - 1);
                if (s.eof) m_fcnt = m_fcnt + 16'd1;
            end
        end
        s.data = m_data; s.row = RAW'(m_row); s.col = CAW'(m_col);
        s.lock = m_locked; s.fcnt = m_fcnt;
    endtask

    function automatic snap_t observe();
        snap_t s;
        s.valid = out_valid; s.data = out_data; s.row = out_row; s.col = out_col;
        s.sof = out_sof; s.eol = out_eol; s.eof = out_eof; s.eoh = err_onehot;
        s.eord = err_order; s.lock = locked; s.fcnt = frame_count;
        return s;
    endfunction

    function automatic stim_t mk(input int r, input int c, input logic [PW-1:0] p);
        stim_t s;
        s.cv = '0; s.rv = '0;
        s.cv[c] = 1'b1; s.rv[r] = 1'b1; s.pix = p;
        return s;
    endfunction

    task automatic add_idle(input int n);
        stim_t s;
        s = '0;
        for (int i = 0; i < n; i++) begin s.pix = PW'($urandom); sq.push_back(s); end
    endtask

    task automatic add_span(input int from, input int to, input int hold, input bit rnd);
        logic [PW-1:0] p;
        for (int pos = from; pos <= to; pos++) begin
            p = rnd ? PW'($urandom) : PW'(pos);
            for (int h = 0; h < hold; h++) sq.push_back(mk(pos / COLS, pos % COLS, p));
        end
    endtask

    // Drives the queued samples one per clock; the DUT view after each edge
    // is paired with the model result of the sample one slot earlier.
    task automatic play();
        snap_t s;
        got.delete(); want.delete();
        foreach (sq[i]) begin
            col_enable = sq[i].cv; row_enable = sq[i].rv; pix_in = sq[i].pix;
            model_step(sq[i], s);
            exp_q.push_back(s);
            @(posedge clk);
            #1;
            got.push_back(observe());
            want.push_back(exp_q.pop_front());
        end
        sq.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; col_enable = '0; row_enable = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic int tally(input int which);
        int n = 0;
        foreach (got[i]) begin
            case (which)
                0: n += int'(got[i].valid);
                1: n += int'(got[i].sof);
                2: n += int'(got[i].eol);
                3: n += int'(got[i].eof);
                default: n += int'(got[i].eoh) + int'(got[i].eord);
            endcase
        end
        return n;
    endfunction

    function automatic int first_idx(input int which);
        foreach (got[i]) begin
            if (which == 0 && got[i].valid) return i;
            if (which == 1 && got[i].eoh) return i;
            if (which == 2 && got[i].eord) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        snap_t o;
        do_reset();
        o = observe();
        checks++;
        if (o !== '0) begin errors++; $display("FAIL reset_state: got %h expected 0", o); end
    endtask

    task automatic test_clean_frame();
        int shown = 0;
        do_reset();
        add_span(0, NPIX - 1, 1, 0);
        add_idle(2);
        play();
        foreach (got[i]) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                if (shown++ < 8) $display("FAIL clean_stream[%0d]: got %h expected %h", i, got[i], want[i]);
            end
        end
        checks++; if (tally(0) != NPIX) begin errors++; $display("FAIL clean_valid_count: got %0d expected %0d", tally(0), NPIX); end
        checks++; if (tally(1) != 1) begin errors++; $display("FAIL clean_sof_count: got %0d expected 1", tally(1)); end
        checks++; if (tally(2) != ROWS) begin errors++; $display("FAIL clean_eol_count: got %0d expected %0d", tally(2), ROWS); end
        checks++; if (tally(3) != 1) begin errors++; $display("FAIL clean_eof_count: got %0d expected 1", tally(3)); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL clean_frame_count: got %0d expected 1", frame_count); end
    endtask

    task automatic test_back_to_back();
        int shown = 0;
        do_reset();
        add_idle(3);
        add_span(0, NPIX - 1, 1, 1);
        add_span(0, NPIX - 1, 1, 1);
        add_idle(2);
        play();
        foreach (got[i]) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                if (shown++ < 8) $display("FAIL b2b_stream[%0d]: got %h expected %h", i, got[i], want[i]);
            end
        end
        checks++; if (tally(1) != 2) begin errors++; $display("FAIL b2b_sof_count: got %0d expected 2", tally(1)); end
        checks++; if (tally(4) != 0) begin errors++; $display("FAIL b2b_errors: got %0d expected 0", tally(4)); end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL b2b_frame_count: got %0d expected 2", frame_count); end
    endtask

    task automatic test_dup_hold();
        int shown = 0;
        do_reset();
        add_span(0, NPIX - 1, 2, 1);
        add_idle(2);
        play();
        foreach (got[i]) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                if (shown++ < 8) $display("FAIL dup_stream[%0d]: got %h expected %h", i, got[i], want[i]);
            end
        end
        checks++; if (tally(0) != NPIX) begin errors++; $display("FAIL dup_valid_count: got %0d expected %0d", tally(0), NPIX); end
        checks++; if (tally(4) != 0) begin errors++; $display("FAIL dup_errors: got %0d expected 0", tally(4)); end
    endtask

    task automatic test_late_start();
        int shown = 0, fv, pre_bad = 0;
        do_reset();
        add_span(3 * COLS + 5, NPIX - 1, 1, 1);
        add_span(0, 9, 1, 1);
        add_idle(2);
        play();
        foreach (got[i]) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                if (shown++ < 8) $display("FAIL late_stream[%0d]: got %h expected %h", i, got[i], want[i]);
            end
        end
        fv = first_idx(0);
        for (int i = 0; i < fv; i++)
            if (got[i].valid || got[i].eoh || got[i].eord || got[i].lock) pre_bad++;
        checks++; if (fv != NPIX - (3 * COLS + 5) + 1) begin errors++; $display("FAIL late_first_valid_idx: got %0d expected %0d", fv, NPIX - (3 * COLS + 5) + 1); end
        checks++; if (pre_bad != 0) begin errors++; $display("FAIL late_activity_before_origin: got %0d expected 0", pre_bad); end
        checks++; if (fv >= 0 && got[fv].lock !== 1'b1) begin errors++; $display("FAIL late_locked_at_origin: got %b expected 1", got[fv].lock); end
    endtask

    task automatic test_multi_hot();
        int shown = 0, mi, ei;
        stim_t s;
        do_reset();
        add_span(0, 2 * COLS + 3, 1, 1);
        mi = sq.size();
        s = mk(2, 7, PW'($urandom)); s.cv[8] = 1'b1; sq.push_back(s);
        add_span(2 * COLS + 4, 2 * COLS + 19, 1, 1);
        add_span(0, 2, 1, 1);
        add_idle(2);
        play();
        foreach (got[i]) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                if (shown++ < 8) $display("FAIL multi_stream[%0d]: got %h expected %h", i, got[i], want[i]);
            end
        end
        ei = first_idx(1);
        checks++; if (ei != mi + 1) begin errors++; $display("FAIL multi_err_timing: got %0d expected %0d", ei, mi + 1); end
        checks++; if (ei >= 0 && got[ei].lock !== 1'b0) begin errors++; $display("FAIL multi_lock_drop: got %b expected 0", got[ei].lock); end
        checks++; if (tally(0) != 2 * COLS + 4 + 3) begin errors++; $display("FAIL multi_valid_count: got %0d expected %0d", tally(0), 2 * COLS + 7); end
    endtask

    task automatic test_order();
        int shown = 0, ji, ei;
        do_reset();
        add_span(0, 10 * COLS + 19, 1, 1);
        ji = sq.size();
        sq.push_back(mk(10, 22, PW'($urandom)));
        add_idle(2);
        play();
        foreach (got[i]) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                if (shown++ < 8) $display("FAIL order_skip_stream[%0d]: got %h expected %h", i, got[i], want[i]);
            end
        end
        ei = first_idx(2);
        checks++; if (ei != ji + 1) begin errors++; $display("FAIL order_skip_timing: got %0d expected %0d", ei, ji + 1); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL order_skip_hunt: got %b expected 0", locked); end

        do_reset();
        add_span(0, 10 * COLS + 19, 1, 1);
        ji = sq.size();
        sq.push_back(mk(0, 0, PW'($urandom)));
        sq.push_back(mk(0, 1, PW'($urandom)));
        add_idle(2);
        play();
        foreach (got[i]) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                if (shown++ < 8) $display("FAIL order_restart_stream[%0d]: got %h expected %h", i, got[i], want[i]);
            end
        end
        checks++;
        if ({got[ji + 1].valid, got[ji + 1].sof, got[ji + 1].eord, got[ji + 1].lock} !== 4'b1111) begin
            errors++;
            $display("FAIL order_restart_flags: got v/sof/err/lock %b%b%b%b expected 1111",
                     got[ji + 1].valid, got[ji + 1].sof, got[ji + 1].eord, got[ji + 1].lock);
        end
    endtask

    task automatic test_midframe_reset();
        int shown = 0, fv;
        snap_t o;
        do_reset();
        add_span(0, COLS + 5, 1, 1);
        play();
        foreach (got[i]) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                if (shown++ < 8) $display("FAIL midrst_pre_stream[%0d]: got %h expected %h", i, got[i], want[i]);
            end
        end
        col_enable = mk(1, 6, '0).cv; row_enable = mk(1, 6, '0).rv;
        rst = 1'b1;
        #1;
        o = observe();
        checks++;
        if (o !== '0) begin errors++; $display("FAIL midrst_async_clear: got %h expected 0", o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        add_span(COLS + 6, 3 * COLS, 1, 1);
        add_span(0, 3, 1, 1);
        add_idle(2);
        play();
        foreach (got[i]) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                if (shown++ < 8) $display("FAIL midrst_post_stream[%0d]: got %h expected %h", i, got[i], want[i]);
            end
        end
        fv = first_idx(0);
        checks++; if (tally(0) != 4) begin errors++; $display("FAIL midrst_valid_count: got %0d expected 4", tally(0)); end
        checks++; if (fv < 0 || got[fv].sof !== 1'b1) begin errors++; $display("FAIL midrst_resume_sof: first valid idx %0d lacks sof", fv); end
    endtask

    task automatic test_random();
        int shown = 0, pos = NPIX - 1, r, a, b;
        stim_t s;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(99);
            if (r < 62) begin
                pos = (pos + 1) % NPIX; sq.push_back(mk(pos / COLS, pos % COLS, PW'($urandom)));
            end else if (r < 72) begin
                sq.push_back(mk(pos / COLS, pos % COLS, PW'($urandom)));
            end else if (r < 78) begin
                add_idle(1);
            end else if (r < 82) begin
                a = $urandom_range(COLS - 1); b = (a + 1 + $urandom_range(COLS - 2)) % COLS;
                s = mk(pos / COLS, a, PW'($urandom)); s.cv[b] = 1'b1;
                if (r == 81) s.rv[(pos / COLS + 1) % ROWS] = 1'b1;
                sq.push_back(s);
            end else if (r < 89) begin
                pos = $urandom_range(NPIX - 1); sq.push_back(mk(pos / COLS, pos % COLS, PW'($urandom)));
            end else if (r < 95) begin
                pos = 0; sq.push_back(mk(0, 0, PW'($urandom)));
            end else begin
                pos = (pos + 2) % NPIX; sq.push_back(mk(pos / COLS, pos % COLS, PW'($urandom)));
            end
        end
        add_idle(2);
        play();
        foreach (got[i]) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                if (shown++ < 8) $display("FAIL random_stream[%0d]: got %h expected %h", i, got[i], want[i]);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_clean_frame();
        test_back_to_back();
        test_dup_hold();
        test_late_start();
        test_multi_hot();
        test_order();
        test_midframe_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/roic_pixel_capture.md
Name: roic_pixel_capture

Overview:
- Receive end of the ROIC row/column scan: consumes the one-hot `row_enable`/`col_enable` vectors produced by the 640x512 traversal sequencer, plus the pixel sample presented alongside them.
- Decodes one-hot to binary coordinates and checks one-hot integrity and raster order.
- Emits a pixel stream tagged with start-of-frame/end-of-line/end-of-frame markers to the downstream frame buffer.

Parameters:
- COLS, 640, columns per row (width of `col_enable`)
- ROWS, 512, rows per frame (width of `row_enable`)
- COL_AW, 10, column address width, >= clog2(COLS)
- ROW_AW, 9, row address width, >= clog2(ROWS)
- PIX_W, 14, pixel sample width

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- col_enable  input  COLS  one-hot column select from scan sequencer
- row_enable  input  ROWS  one-hot row select from scan sequencer
- pix_in  input  PIX_W  pixel sample aligned with enables
- out_valid  output  1  registered pixel valid strobe
- out_data  output  PIX_W  pixel value
- out_row  output  ROW_AW  decoded row of out_data
- out_col  output  COL_AW  decoded column of out_data
- out_sof  output  1  with out_valid at (0,0)
- out_eol  output  1  with out_valid at col COLS-1
- out_eof  output  1  with out_valid at (ROWS-1,COLS-1)
- err_onehot  output  1  one-cycle pulse: multi-hot enable detected
- err_order  output  1  one-cycle pulse: out-of-order coordinate while LOCKED
- locked  output  1  high in LOCKED state
- frame_count  output  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (async): all outputs 0. State = HUNT. Expected position = (0,0). Last-accepted-valid flag = 0.
- Stage 1 (registered):
  - Encode each enable vector to {none, one, many} plus binary index; index is meaningful only when classification is one.
  - Register pix_in, indices, and classifications.
- Stage 2 (registered): classification, FSM, and output.
- Latency: an input sample is reflected on outputs exactly 2 clocks later.
- Sample classes (evaluated in stage 2):
  - IDLE: either vector all-zero -> ignored, no error, state unchanged.
  - MULTI: either vector has >1 bit set -> err_onehot pulse, sample dropped, state -> HUNT, expected -> (0,0).
  - DUP: coordinates equal to the last accepted sample -> ignored silently. Allows the sequencer to hold enables multiple cycles.
  - VALID: exactly one bit in each vector, not DUP.
- FSM HUNT:
  - VALID at (0,0) -> accept with out_sof, state -> LOCKED, expected -> (0,1).
  - Any other VALID -> dropped, no error.
- FSM LOCKED:
  - VALID equal to expected -> accept, advance expected: col+1; at col COLS-1 wrap col to 0 and row+1; at (ROWS-1,COLS-1) wrap to (0,0).
  - VALID not equal to expected, and not (0,0) -> err_order pulse, dropped, state -> HUNT.
  - VALID at (0,0) while expected is not (0,0) -> err_order pulse, accepted as new frame start (out_sof), expected -> (0,1), stay LOCKED.
- Accept output:
  - out_valid=1 for one cycle with out_data/out_row/out_col.
  - Markers set per port definitions.
  - At out_eof, frame_count increments in the same cycle; state stays LOCKED.
- When out_valid=0: out_data/out_row/out_col hold their last values; markers are 0.
- Reset asserted mid-frame: pipeline is flushed; no partial-frame outputs after deassert. Capture resumes only at the next (0,0).
- `locked` reflects the registered state.

Test Plan:
- Reset, then a clean raster of 640x512 one pixel/clock, pix_in=row*640+col mod 2^14 -> 327680 out_valid pulses with matching data; out_sof only on the first; out_eol 512 times; out_eof once at (511,639); frame_count=1.
- Two back-to-back frames, first preceded by 3 idle cycles -> idle cycles ignored; frame_count=2; sof at the first pixel of each frame; no errors.
- Each enable held 2 cycles (DUP) -> identical output stream as a single-cycle scan; no errors.
- Start scan at (3,5) after reset -> no out_valid and no error until (0,0); locked rises at the first (0,0).
- Mid-frame, col_enable=bits 7 and 8 set -> err_onehot pulses 2 clocks later; locked drops; pixels dropped until next (0,0).
- LOCKED, expected (10,20), input (10,22) -> err_order pulse, HUNT. Separate case: expected (10,20), input (0,0) -> err_order plus out_sof, stays locked.
